board_state_hist: RTL and testbench
===================================

# board_state_hist

Parametrised registered holder for the game FSM's current state code and the ROWS×COLS tile matrix. It is the next generation of the plain state/matrix register, adding:
- an asynchronous reset to a known board;
- an explicit commit enable;
- a circular undo history of up to DEPTH prior (state, matrix) snapshots.

It sits between the move/merge combinational logic (next state, next matrix) and the display and FSM decode logic (current state, current matrix).

## Interface
- ROWS, 4, matrix rows
- COLS, 4, matrix columns
- TILE_W, 12, bits per tile
- STATE_W, 3, FSM state code width
- DEPTH, 4, undo snapshots retained (≥2, power of two)
- RST_STATE, 0, state code loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- commit  in  1  load D/matrix_D into Q/matrix_Q this edge
- undo  in  1  restore most recent snapshot this edge
- D  in  STATE_W  next state
- matrix_D  in  TILE_W × [ROWS][COLS]  next matrix
- Q  out  STATE_W  current state
- matrix_Q  out  TILE_W × [ROWS][COLS]  current matrix
- undo_avail  out  1  hist_count != 0
- hist_count  out  $clog2(DEPTH+1)  snapshots held
- undo_err  out  1  one-cycle pulse: undo requested with empty history

## Operation
- Reset (rst=1, any time, asynchronous):
  - Q=RST_STATE, matrix_Q all zero;
  - wr_ptr=0, hist_count=0, undo_err=0;
  - history contents are don't-care.
- Neither commit nor undo: all registers hold.
- commit=1, undo=0:
  - Q←D, matrix_Q←matrix_D.
  - If matrix_D ≠ matrix_Q (any tile differs), push the old (Q, matrix_Q) to hist[wr_ptr], then wr_ptr←wr_ptr+1 mod DEPTH and hist_count←min(hist_count+1, DEPTH).
  - If the matrix is unchanged, update Q only and do not push. A state-only change never consumes history.
- Full history (hist_count=DEPTH) on push: the oldest snapshot is overwritten, wr_ptr advances, and hist_count stays DEPTH.
- undo=1, commit=0:
  - If hist_count>0: Q, matrix_Q ← hist[wr_ptr−1 mod DEPTH]; wr_ptr decrements (wrapping), hist_count−1.
  - If hist_count=0: registers hold and undo_err=1 for one cycle.
- commit=1 and undo=1 together: undo wins; commit is ignored that cycle.
- undo_err is registered. It is 1 only in the cycle after an empty undo and returns to 0 on the following edge unless another empty undo occurs.
- Matrix comparison is exact bitwise over all ROWS×COLS×TILE_W bits. There is no arithmetic on tile values.

## Timing
- Commit and undo latency is 1 cycle: the request is sampled on edge N and outputs change immediately after edge N.
- undo_avail and hist_count reflect post-edge state. They are combinational from registered hist_count and never from same-cycle inputs.
- Back-to-back commits or undos on consecutive cycles are fully supported with no bubble.
- Reset mid-operation drops the history. The first undo after reset raises undo_err.
- Q and matrix_Q are glitch-free register outputs, with no input-to-output combinational path.

## Configuration
- BOARD_HISTORY_EN defined:
  - history RAM, pointers and compare logic are compiled in;
  - behaviour is as above.
- BOARD_HISTORY_EN undefined:
  - no history storage;
  - commit loads D/matrix_D unconditionally;
  - undo is ignored and treated as idle, and commit takes effect even when undo is high;
  - undo_avail=0, hist_count=0 and undo_err=0 constantly.

## Test plan
- Reset check: assert rst asynchronously mid-cycle with RST_STATE=2. The outputs must read Q=2, all tiles 0 and hist_count=0 before the next edge.
- Commit/undo round trip: commit matrix with tile[0][0]=2, then commit tile[0][0]=4, D=3. Expect hist_count=2. Then undo. Expect matrix tile[0][0]=2, the prior Q, and hist_count=1.
- Unchanged matrix: commit the identical matrix with D=5. Expect Q=5 and hist_count unchanged.
- Overflow with DEPTH=4: six distinct commits with tile[3][3]=1..6. Expect hist_count=4. Four undos then restore 5, 4, 3, 2. A fifth undo yields undo_err=1 for one cycle with registers held.
- Simultaneous commit=1 and undo=1 with hist_count=1: undo executes, D is discarded and hist_count=0.
- Reset mid-stream with hist_count=3: after reset, an undo must give undo_err=1 and hist_count=0. Repeat with BOARD_HISTORY_EN undefined: undo is ignored, undo_err stays 0 and hist_count stays 0.

Source files
------------

// File: rtl/board_state_hist.sv
// board_state_hist
// Registered holder for the game FSM state code and the ROWS x COLS tile
// matrix. Matrix-changing commits push the old (state, matrix) pair into a
// circular undo history of DEPTH entries. An undo restores the newest entry.
// Compile-time option: BOARD_HISTORY_EN. When it is defined, the history
// storage, pointers and matrix compare are built. When it is undefined,
// the block is a plain commit-enabled register and the undo status outputs
// are tied low.
module board_state_hist #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int TILE_W    = 12,
    parameter int STATE_W   = 3,
    parameter int DEPTH     = 4,
    parameter int RST_STATE = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        commit,
    input  logic                                        undo,
    input  logic [STATE_W-1:0]                          D,
    input  logic [ROWS-1:0][COLS-1:0][TILE_W-1:0]       matrix_D,
    output logic [STATE_W-1:0]                          Q,
    output logic [ROWS-1:0][COLS-1:0][TILE_W-1:0]       matrix_Q,
    output logic                                        undo_avail,
    output logic [$clog2(DEPTH+1)-1:0]                  hist_count,
    output logic                                        undo_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [ROWS-1:0][COLS-1:0][TILE_W-1:0] mat_t;

    logic [STATE_W-1:0] state_q, state_d;
    mat_t               mat_q,   mat_d;

    assign Q        = state_q;
    assign matrix_Q = mat_q;

`ifdef BOARD_HISTORY_EN

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]   hist_count_q, hist_count_d;
    logic               undo_err_q,   undo_err_d;
    logic               push;
    logic [PTR_W-1:0]   rd_ptr;

    logic [STATE_W-1:0] hist_state_q [DEPTH];
    mat_t               hist_mat_q   [DEPTH];

    // DEPTH is a power of two, so the pointer wraps by plain truncation.
    assign rd_ptr = wr_ptr_q - PTR_W'(1);

    // Next-state decode: undo has priority over commit; pushes only on a matrix change.
    always_comb begin
        state_d      = state_q;
        mat_d        = mat_q;
        wr_ptr_d     = wr_ptr_q;
        hist_count_d = hist_count_q;
        undo_err_d   = 1'b0;
        push         = 1'b0;
        if (undo) begin
            if (hist_count_q != '0) begin
                state_d      = hist_state_q[rd_ptr];
                mat_d        = hist_mat_q[rd_ptr];
                wr_ptr_d     = rd_ptr;
                hist_count_d = hist_count_q - CNT_W'(1);
            end else begin
                undo_err_d = 1'b1;
            end
        end else if (commit) begin
            state_d = D;
            mat_d   = matrix_D;
            if (matrix_D != mat_q) begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (hist_count_q != CNT_W'(DEPTH)) begin
                    hist_count_d = hist_count_q + CNT_W'(1);
                end
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STATE_W'(RST_STATE);
            mat_q        <= '0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            undo_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mat_q        <= mat_d;
            wr_ptr_q     <= wr_ptr_d;
            hist_count_q <= hist_count_d;
            undo_err_q   <= undo_err_d;
        end
    end

    // Snapshot storage: no reset, since hist_count marks which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            hist_state_q[wr_ptr_q] <= state_q;
            hist_mat_q[wr_ptr_q]   <= mat_q;
        end
    end

    assign undo_avail = (hist_count_q != '0);
    assign hist_count = hist_count_q;
    assign undo_err   = undo_err_q;

`else

    logic unused_undo;
    assign unused_undo = undo;

    // Without history the commit is an unconditional load and undo is ignored.
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        if (commit) begin
            state_d = D;
            mat_d   = matrix_D;
        end
    end

    // State and matrix registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_W'(RST_STATE);
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
        end
    end

    assign undo_avail = 1'b0;
    assign hist_count = '0;
    assign undo_err   = 1'b0;

`endif

endmodule

// File: tb/tb_board_state_hist.sv
// Scoreboard bench for board_state_hist (ROWS=COLS=4, TILE_W=12, STATE_W=3,
// DEPTH=4, RST_STATE=2). The driver pushes hand-computed expectations. The
// monitor pops one entry after each clock edge that follows an operation.
module tb_board_state_hist;

    typedef logic [3:0][3:0][11:0] mat_t;

    typedef struct packed {
        logic [2:0] st;
        mat_t       mat;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       commit = 1'b0;
    logic       undo = 1'b0;
    logic [2:0] d_in = '0;
    mat_t       mat_in = '0;
    logic [2:0] q_out;
    mat_t       mat_out;
    logic       undo_avail;
    logic [2:0] hist_count;
    logic       undo_err;

    int n_pass  = 0;
    int n_total = 0;

    exp_t sb[$];

    board_state_hist #(
        .ROWS(4), .COLS(4), .TILE_W(12), .STATE_W(3), .DEPTH(4), .RST_STATE(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .commit     (commit),
        .undo       (undo),
        .D          (d_in),
        .matrix_D   (mat_in),
        .Q          (q_out),
        .matrix_Q   (mat_out),
        .undo_avail (undo_avail),
        .hist_count (hist_count),
        .undo_err   (undo_err)
    );

    always #5 clk = ~clk;

    function automatic mat_t mk(input logic [11:0] t00, input logic [11:0] t33);
        mat_t m;
        m = '0;
        m[0][0] = t00;
        m[3][3] = t33;
        return m;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input exp_t e);
        chk("Q", 192'(q_out), 192'(e.st));
        chk("matrix_Q", 192'(mat_out), 192'(e.mat));
        chk("hist_count", 192'(hist_count), 192'(e.cnt));
        chk("undo_avail", 192'(undo_avail), 192'(e.cnt != 3'd0));
        chk("undo_err", 192'(undo_err), 192'(e.err));
    endtask

    // One operation per cycle: drive at negedge, expectation goes to the scoreboard.
    task automatic op(input logic c, input logic u, input logic [2:0] d, input mat_t m,
                      input logic [2:0] es, input mat_t em, input logic [2:0] ec,
                      input logic ee);
        exp_t e;
        @(negedge clk);
        commit = c;
        undo   = u;
        d_in   = d;
        mat_in = m;
        e.st = es; e.mat = em; e.cnt = ec; e.err = ee;
        sb.push_back(e);
    endtask

    task automatic idle_settle();
        @(negedge clk);
        commit = 1'b0;
        undo   = 1'b0;
        @(posedge clk);
        #3;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, " reset Q"}, 192'(q_out), 192'(3'd2));
        chk({tag, " reset matrix"}, 192'(mat_out), 192'(0));
        chk({tag, " reset hist_count"}, 192'(hist_count), 192'(0));
        chk({tag, " reset undo_err"}, 192'(undo_err), 192'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every result lands right after a rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin
        #1;
        async_reset("power-on");

`ifdef BOARD_HISTORY_EN
        // commit/undo round trip
        op(1, 0, 3'd1, mk(2, 0), 3'd1, mk(2, 0), 3'd1, 0);
        op(1, 0, 3'd3, mk(4, 0), 3'd3, mk(4, 0), 3'd2, 0);
        op(0, 1, 3'd0, '0,       3'd1, mk(2, 0), 3'd1, 0);
        // identical matrix: state-only change, no push
        op(1, 0, 3'd5, mk(2, 0), 3'd5, mk(2, 0), 3'd1, 0);
        // commit and undo together: undo wins
        op(1, 1, 3'd7, mk(9, 9), 3'd2, mk(0, 0), 3'd0, 0);
        // empty undo pulses undo_err for one cycle
        op(0, 1, 3'd0, '0,       3'd2, mk(0, 0), 3'd0, 1);
        op(0, 0, 3'd0, '0,       3'd2, mk(0, 0), 3'd0, 0);
        // overflow: six matrix-changing commits, oldest two overwritten
        op(1, 0, 3'd1, mk(0, 1), 3'd1, mk(0, 1), 3'd1, 0);
        op(1, 0, 3'd2, mk(0, 2), 3'd2, mk(0, 2), 3'd2, 0);
        op(1, 0, 3'd3, mk(0, 3), 3'd3, mk(0, 3), 3'd3, 0);
        op(1, 0, 3'd4, mk(0, 4), 3'd4, mk(0, 4), 3'd4, 0);
        op(1, 0, 3'd5, mk(0, 5), 3'd5, mk(0, 5), 3'd4, 0);
        op(1, 0, 3'd6, mk(0, 6), 3'd6, mk(0, 6), 3'd4, 0);
        op(0, 1, 3'd0, '0,       3'd5, mk(0, 5), 3'd3, 0);
        op(0, 1, 3'd0, '0,       3'd4, mk(0, 4), 3'd2, 0);
        op(0, 1, 3'd0, '0,       3'd3, mk(0, 3), 3'd1, 0);
        op(0, 1, 3'd0, '0,       3'd2, mk(0, 2), 3'd0, 0);
        op(0, 1, 3'd0, '0,       3'd2, mk(0, 2), 3'd0, 1);
        op(0, 1, 3'd0, '0,       3'd2, mk(0, 2), 3'd0, 1);
        op(0, 0, 3'd0, '0,       3'd2, mk(0, 2), 3'd0, 0);
        // reset mid-stream drops history
        op(1, 0, 3'd1, mk(0, 7), 3'd1, mk(0, 7), 3'd1, 0);
        op(1, 0, 3'd2, mk(0, 8), 3'd2, mk(0, 8), 3'd2, 0);
        op(1, 0, 3'd3, mk(0, 9), 3'd3, mk(0, 9), 3'd3, 0);
        idle_settle();
        async_reset("mid-stream");
        op(0, 1, 3'd0, '0,       3'd2, mk(0, 0), 3'd0, 1);
        op(0, 0, 3'd0, '0,       3'd2, mk(0, 0), 3'd0, 0);
`else
        // no history: commit always loads, undo ignored
        op(1, 0, 3'd1, mk(2, 0), 3'd1, mk(2, 0), 3'd0, 0);
        op(1, 0, 3'd5, mk(2, 0), 3'd5, mk(2, 0), 3'd0, 0);
        op(0, 1, 3'd0, '0,       3'd5, mk(2, 0), 3'd0, 0);
        op(1, 1, 3'd3, mk(4, 0), 3'd3, mk(4, 0), 3'd0, 0);
        op(0, 0, 3'd6, mk(7, 7), 3'd3, mk(4, 0), 3'd0, 0);
        op(1, 0, 3'd1, mk(0, 7), 3'd1, mk(0, 7), 3'd0, 0);
        op(1, 0, 3'd2, mk(0, 8), 3'd2, mk(0, 8), 3'd0, 0);
        op(1, 0, 3'd3, mk(0, 9), 3'd3, mk(0, 9), 3'd0, 0);
        idle_settle();
        async_reset("mid-stream");
        op(0, 1, 3'd0, '0,       3'd2, mk(0, 0), 3'd0, 0);
        op(0, 0, 3'd0, '0,       3'd2, mk(0, 0), 3'd0, 0);
`endif

        @(negedge clk);
        commit = 1'b0;
        undo   = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
